// File: rtl/req_scheduler.sv
// Pending-request scheduler: edge-detects request lines into a pending register
// and hands one granted index at a time to a valid/ready consumer.
module req_scheduler #(
    parameter int  REQ_WIDTH = 8,
    parameter int  MODE      = 0,
    localparam int BIN_WIDTH = $clog2(REQ_WIDTH)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [REQ_WIDTH-1:0] i_req,
    input  logic                 i_ready,
    input  logic                 i_clr_ovr,
    output logic                 o_valid,
    output logic [BIN_WIDTH-1:0] o_bin,
    output logic [REQ_WIDTH-1:0] o_pending,
    output logic                 o_overrun
);

    logic [REQ_WIDTH-1:0] req_q;
    logic [REQ_WIDTH-1:0] pending_q;
    logic [REQ_WIDTH-1:0] pending_d;
    logic [REQ_WIDTH-1:0] req_rise;
    logic [REQ_WIDTH-1:0] clr_mask;
    logic [REQ_WIDTH-1:0] ovr_hit;
    logic [BIN_WIDTH-1:0] ptr_q;
    logic [BIN_WIDTH-1:0] sel_idx;
    logic                 sel_found;
    logic                 load;
    int                   rr_dist;
    int                   rr_best;

    assign req_rise  = i_req & ~req_q;
    assign load      = ~o_valid | i_ready;
    assign o_pending = pending_q;

    // Round-robin ranks each bit by its distance above the last loaded index.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sel_idx   = '0;
        sel_found = 1'b0;
        rr_dist   = 0;
        rr_best   = REQ_WIDTH;
        if (MODE == 0) begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                if (pending_q[i]) begin
                    sel_idx   = BIN_WIDTH'(i);
                    sel_found = 1'b1;
                end
            end
        end else begin
            for (int i = 0; i < REQ_WIDTH; i++) begin
                rr_dist = i - int'(ptr_q) - 1;
                if (rr_dist < 0) rr_dist = rr_dist + REQ_WIDTH;
                if (pending_q[i] && (rr_dist < rr_best)) begin
                    rr_best   = rr_dist;
                    sel_idx   = BIN_WIDTH'(i);
                    sel_found = 1'b1;
                end
            end
        end
    end

    // Set beats clear: a fresh edge on the bit being loaded re-arms it without overrun.
    always_comb begin
        clr_mask = '0;
        if (load && sel_found) clr_mask[sel_idx] = 1'b1;
        ovr_hit   = req_rise & pending_q & ~clr_mask;
        pending_d = (pending_q & ~clr_mask) | req_rise;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers sample together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            req_q     <= '0;
            pending_q <= '0;
            o_valid   <= 1'b0;
            o_bin     <= '0;
            o_overrun <= 1'b0;
            ptr_q     <= BIN_WIDTH'(REQ_WIDTH - 1);
        end else begin
            req_q     <= i_req;
            pending_q <= pending_d;
            if (load) begin
                o_valid <= sel_found;
                if (sel_found) begin
                    o_bin <= sel_idx;
                    ptr_q <= sel_idx;
                end
            end
            if (|ovr_hit) begin
                o_overrun <= 1'b1;
            end else if (i_clr_ovr) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_req_scheduler.sv
// Bench for req_scheduler: fixed-priority and round-robin instances share stimulus
// and are compared every cycle against a queue-level reference model.
module tb_req_scheduler;

    localparam int W = 8;

    logic         i_clk;
    logic         i_rst_n;
    logic [W-1:0] i_req;
    logic         i_ready;
    logic         i_clr_ovr;

    logic         v0, v1, ov0, ov1;
    logic [2:0]   b0, b1;
    logic [W-1:0] p0, p1;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state, index 0 = fixed priority, 1 = round-robin.
    bit [W-1:0] m_pend  [2];
    bit [W-1:0] m_prev  [2];
    bit         m_valid [2];
    bit         m_ovr   [2];
    int         m_bin   [2];
    int         m_ptr   [2];

    req_scheduler #(.REQ_WIDTH(W), .MODE(0)) dut0 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_ready(i_ready),
        .i_clr_ovr(i_clr_ovr), .o_valid(v0), .o_bin(b0), .o_pending(p0),
        .o_overrun(ov0)
    );

    req_scheduler #(.REQ_WIDTH(W), .MODE(1)) dut1 (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_ready(i_ready),
        .i_clr_ovr(i_clr_ovr), .o_valid(v1), .o_bin(b1), .o_pending(p1),
        .o_overrun(ov1)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_prev[m]  = '0;
            m_valid[m] = 1'b0;
            m_ovr[m]   = 1'b0;
            m_bin[m]   = 0;
            m_ptr[m]   = W - 1;
        end
    endtask

    // One clock edge of the scheduling rules, applied to model m.
    task automatic model_step(input int m);
        int sel;
        bit hit;
        sel = -1;
        hit = 1'b0;
        if (!(m_valid[m] && !i_ready)) begin
            if (m == 0) begin
                for (int n = W - 1; n >= 0; n--)
                    if (sel < 0 && m_pend[m][n]) sel = n;
            end else begin
                for (int k = 1; k <= W; k++)
                    if (sel < 0 && m_pend[m][(m_ptr[m] + k) % W]) sel = (m_ptr[m] + k) % W;
            end
            if (sel >= 0) begin
                m_valid[m]     = 1'b1;
                m_bin[m]       = sel;
                m_ptr[m]       = sel;
                m_pend[m][sel] = 1'b0;
            end else begin
                m_valid[m] = 1'b0;
            end
        end
        for (int n = 0; n < W; n++) begin
            if (i_req[n] && !m_prev[m][n]) begin
                if (m_pend[m][n]) hit = 1'b1;
                m_pend[m][n] = 1'b1;
            end
        end
        if (hit) m_ovr[m] = 1'b1;
        else if (i_clr_ovr) m_ovr[m] = 1'b0;
        m_prev[m] = i_req;
    endtask

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            check($sformatf("m%0d_valid", m), int'(m == 0 ? v0 : v1), int'(m_valid[m]));
            if (m_valid[m])
                check($sformatf("m%0d_bin", m), int'(m == 0 ? b0 : b1), m_bin[m]);
            check($sformatf("m%0d_pending", m), int'(m == 0 ? p0 : p1), int'(m_pend[m]));
            check($sformatf("m%0d_overrun", m), int'(m == 0 ? ov0 : ov1), int'(m_ovr[m]));
        end
    endtask

    task automatic cycle();
        @(posedge i_clk);
        if (!i_rst_n) model_reset();
        else for (int m = 0; m < 2; m++) model_step(m);
        @(negedge i_clk);
        compare_all();
    endtask

    task automatic drain();
        i_req   = '0;
        i_ready = 1'b1;
        repeat (12) cycle();
    endtask

    initial begin
        i_rst_n   = 1'b0;
        i_req     = '0;
        i_ready   = 1'b0;
        i_clr_ovr = 1'b0;
        model_reset();
        repeat (2) @(negedge i_clk);
        compare_all();
        check("rst_bin0", int'(b0), 0);

        // Three requests at once, consumer always ready.
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        i_req   = 8'h92;
        cycle();
        check("p_92", int'(p0), 8'h92);
        check("v_before", int'(v0), 0);
        cycle();
        check("m0_first", int'(b0), 7);
        check("m1_first", int'(b1), 1);
        cycle();
        check("m0_second", int'(b0), 4);
        check("m1_second", int'(b1), 4);
        cycle();
        check("m0_third", int'(b0), 1);
        check("m1_third", int'(b1), 7);
        cycle();
        check("m0_done", int'(v0), 0);
        check("m1_empty", int'(p1), 0);
        i_req = '0;
        cycle();
        i_req = 8'h82;
        cycle();
        i_req = '0;
        cycle();
        check("m1_wrap_a", int'(b1), 1);
        check("m0_wrap_a", int'(b0), 7);
        cycle();
        check("m1_wrap_b", int'(b1), 7);
        drain();

        // Backpressure holds the granted index.
        i_ready = 1'b0;
        i_req   = 8'h20;
        cycle();
        i_req = '0;
        cycle();
        for (int i = 0; i < 10; i++) begin
            check("bp_valid", int'(v0), 1);
            check("bp_bin", int'(b0), 5);
            cycle();
        end
        i_ready = 1'b1;
        cycle();
        check("bp_release", int'(v0), 0);

        // Repeated pulses on one bit while the consumer stalls.
        i_ready = 1'b0;
        i_req   = 8'h08;
        cycle();
        i_req = '0;
        cycle();
        check("ovr_bin3", int'(b0), 3);
        i_req = 8'h08;
        cycle();
        check("ovr_pend", int'(p0), 8'h08);
        check("ovr_not_yet", int'(ov0), 0);
        i_req = '0;
        cycle();
        i_req = 8'h08;
        cycle();
        check("ovr_set", int'(ov0), 1);
        i_req     = '0;
        i_clr_ovr = 1'b1;
        cycle();
        i_clr_ovr = 1'b0;
        check("ovr_clr", int'(ov0), 0);
        drain();

        // Load of bit 2 coincides with a fresh edge on bit 2.
        i_ready = 1'b0;
        i_req   = 8'h40;
        cycle();
        i_req = '0;
        cycle();
        i_req = 8'h04;
        cycle();
        i_req = '0;
        cycle();
        i_req   = 8'h04;
        i_ready = 1'b1;
        cycle();
        check("svc_bin", int'(b0), 2);
        check("svc_pend2", int'(p0[2]), 1);
        check("svc_ovr", int'(ov0), 0);
        check("svc_bin_rr", int'(b1), 2);
        drain();

        // Asynchronous reset in the middle of traffic.
        i_ready = 1'b0;
        i_req   = 8'h01;
        cycle();
        i_req = 8'hF0;
        cycle();
        check("mid_pend", int'(p0), 8'hF0);
        check("mid_valid", int'(v0), 1);
        i_req = 8'h01;
        #2 i_rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_bin", int'(b0), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        cycle();
        cycle();
        check("post_rst_bin", int'(b0), 0);
        check("post_rst_valid", int'(v1), 1);
        drain();

        // Randomised traffic, backpressure and overrun clears.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) i_req = W'($urandom);
            i_ready   = ($urandom_range(0, 3) != 0);
            i_clr_ovr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        i_clr_ovr = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/req_scheduler.md
REQ_SCHEDULER -- requirements
Module: req_scheduler

Interface
REQ-001 SHALL have parameter REQ_WIDTH, default 8, giving the number of request lines; legal range 2..32, non-power-of-two allowed.
REQ-002 SHALL have parameter MODE, default 0, selecting arbitration: 0 = fixed priority, 1 = round-robin.
REQ-003 SHALL derive local BIN_WIDTH = clog2(REQ_WIDTH); it is not overridable.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port i_req, input, REQ_WIDTH bits: level request lines, synchronous to i_clk.
REQ-007 SHALL have port i_ready, input, 1 bit: consumer accepts o_bin.
REQ-008 SHALL have port i_clr_ovr, input, 1 bit: synchronous clear of o_overrun.
REQ-009 SHALL have port o_valid, output, 1 bit: o_bin holds a granted index.
REQ-010 SHALL have port o_bin, output, BIN_WIDTH bits: binary index of granted request.
REQ-011 SHALL have port o_pending, output, REQ_WIDTH bits: current pending-request register.
REQ-012 SHALL have port o_overrun, output, 1 bit: sticky, a request edge hit an already-pending bit.

Function
REQ-013 SHALL register i_req each cycle and detect rising edges (i_req & ~previous i_req) per bit.
REQ-014 SHALL set pending bit n on a rising edge of i_req[n]; level high without an edge sets nothing.
REQ-015 SHALL define handshake as o_valid & i_ready at a clock edge.
REQ-016 SHALL load the output register whenever o_valid is 0 or a handshake occurs, using pending as it stood before that edge: if any bit is pending, set o_valid=1, set o_bin to the selected index, and clear that pending bit; if none is pending, set o_valid=0.
REQ-017 SHALL hold o_valid and o_bin stable while o_valid=1 and i_ready=0.
REQ-018 MODE 0 SHALL select the highest pending index.
REQ-019 MODE 1 SHALL search upward from (last loaded index + 1), wrapping from REQ_WIDTH-1 to 0, and select the first pending index; the pointer updates only on a load.
REQ-020 SHALL give a latency of 2 cycles: edge sampled at clock k sets pending after k; o_valid/o_bin are valid after k+1 when the output register is free.
REQ-021 On a new edge for bit n in the same cycle bit n is loaded and cleared, set SHALL win: bit n stays pending, with no overrun.
REQ-022 On a new edge for bit n already pending and not being loaded that cycle, SHALL set o_overrun; the pending state is unchanged, so the request is merged.
REQ-023 SHALL treat a bit already in the output register as not pending, so a new edge on it sets pending normally.
REQ-024 SHALL keep o_overrun set until i_clr_ovr=1 at a clock edge; a new overrun in the same cycle wins over the clear.
REQ-025 SHALL drive o_pending directly from the pending register, with no combinational path from i_req.

Reset
REQ-026 While i_rst_n=0, SHALL immediately force o_valid=0, o_bin=0, o_pending=0, o_overrun=0, the previous-i_req register to 0, and the round-robin pointer to REQ_WIDTH-1, so that the first search starts at index 0.
REQ-027 SHALL treat any i_req bit high at the first edge after reset release as a rising edge.
REQ-028 Reset asserted mid-operation SHALL discard all pending and granted requests with no handshake.

Verification (REQ_WIDTH=8)
REQ-029 MODE 0: i_req 0x00 -> 0x92 held, i_ready=1 -> o_valid high from cycle +2, o_bin = 7, 4, 1 on consecutive cycles, then o_valid=0, o_pending=0x00.
REQ-030 MODE 1, same stimulus -> o_bin = 1, 4, 7; then a pulse on bits 1 and 7 -> o_bin = 1 then 7, because the pointer starts the search at 0 after wrap.
REQ-031 Backpressure: i_ready=0, pulse bit 5 -> o_valid=1, o_bin=5, held for 10 cycles; i_ready=1 for one cycle -> o_valid=0 next cycle.
REQ-032 Overrun: i_ready=0, three single-cycle pulses on bit 3 -> pulse 1 goes to o_bin=3; pulse 2 gives o_pending=0x08; pulse 3 gives o_overrun=1; i_clr_ovr pulse -> o_overrun=0.
REQ-033 Set-vs-clear: bit 2 pending, and its load cycle coincides with a new edge on bit 2 -> o_bin=2 and o_pending[2] stays 1, o_overrun=0.
REQ-034 Reset mid-operation: o_valid=1 with o_pending=0xF0, i_rst_n low asynchronously between clock edges -> all outputs 0 before the next clock edge; after release, i_req held at 0x01 -> o_bin=0 two cycles later.
